// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are ready, issues one per cycle.
// Issue one cycle after operands are ready; full=1 rejects dispatch; rdy=0 freezes all state.
module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   input  logic             disp_valid,
   input  logic [4:0]       disp_op,
   input  logic [ROB_W-1:0] disp_rob_id,
   input  logic [31:0]      disp_vj,
   input  logic [31:0]      disp_vk,
   input  logic             disp_qj_valid,
   input  logic             disp_qk_valid,
   input  logic [ROB_W-1:0] disp_qj,
   input  logic [ROB_W-1:0] disp_qk,
   input  logic             cdb_alu_valid,
   input  logic [ROB_W-1:0] cdb_alu_rob_id,
   input  logic [31:0]      cdb_alu_value,
   input  logic             cdb_lsb_valid,
   input  logic [ROB_W-1:0] cdb_lsb_rob_id,
   input  logic [31:0]      cdb_lsb_value,
   output logic             full,
   output logic             alu_valid,
   output logic [4:0]       alu_op,
   output logic [31:0]      alu_v1,
   output logic [31:0]      alu_v2,
   output logic [ROB_W-1:0] alu_rob_id
);

   localparam int IDX_W = $clog2(RS_SIZE);

   typedef struct packed {
      logic             busy;
      logic [4:0]       op;
      logic [31:0]      vj;
      logic [31:0]      vk;
      logic             qj_valid;
      logic [ROB_W-1:0] qj;
      logic             qk_valid;
      logic [ROB_W-1:0] qk;
      logic [ROB_W-1:0] rob_id;
   } entry_t;

   entry_t           ent_q [RS_SIZE];
   entry_t           ent_d [RS_SIZE];
   logic             alu_valid_q, alu_valid_d;
   logic [4:0]       alu_op_q, alu_op_d;
   logic [31:0]      alu_v1_q, alu_v1_d;
   logic [31:0]      alu_v2_q, alu_v2_d;
   logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

   logic             free_found, sel_found;
   logic [IDX_W-1:0] free_idx, sel_idx;

   // CDB match for one tag; the ALU port wins when both carry the same tag.
   function automatic logic [32:0] cdb_fwd(input logic [ROB_W-1:0] tag);
      if (cdb_alu_valid && cdb_alu_rob_id == tag)
         return {1'b1, cdb_alu_value};
      else if (cdb_lsb_valid && cdb_lsb_rob_id == tag)
         return {1'b1, cdb_lsb_value};
      else
         return 33'd0;
   endfunction

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!ent_q[i].busy) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ent_q[i].busy && !ent_q[i].qj_valid && !ent_q[i].qk_valid) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   assign full = ~free_found;

   always_comb begin
      logic [32:0] fj, fk;
      fj = 33'd0;
      fk = 33'd0;
      for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
      alu_valid_d = alu_valid_q;
      alu_op_d    = alu_op_q;
      alu_v1_d    = alu_v1_q;
      alu_v2_d    = alu_v2_q;
      alu_rob_d   = alu_rob_q;
      if (rdy) begin
         if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            alu_valid_d = 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (ent_q[i].busy) begin
                  fj = cdb_fwd(ent_q[i].qj);
                  fk = cdb_fwd(ent_q[i].qk);
                  if (ent_q[i].qj_valid && fj[32]) begin
                     ent_d[i].vj       = fj[31:0];
                     ent_d[i].qj_valid = 1'b0;
                  end
                  if (ent_q[i].qk_valid && fk[32]) begin
                     ent_d[i].vk       = fk[31:0];
                     ent_d[i].qk_valid = 1'b0;
                  end
               end
            end
            alu_valid_d = sel_found;
            if (sel_found) begin
               alu_op_d             = ent_q[sel_idx].op;
               alu_v1_d             = ent_q[sel_idx].vj;
               alu_v2_d             = ent_q[sel_idx].vk;
               alu_rob_d            = ent_q[sel_idx].rob_id;
               ent_d[sel_idx].busy  = 1'b0;
            end
            // Free slot comes from registered busy, so it never collides with the issuing entry.
            if (disp_valid && free_found) begin
               fj = cdb_fwd(disp_qj);
               fk = cdb_fwd(disp_qk);
               ent_d[free_idx].busy     = 1'b1;
               ent_d[free_idx].op       = disp_op;
               ent_d[free_idx].rob_id   = disp_rob_id;
               ent_d[free_idx].qj       = disp_qj;
               ent_d[free_idx].qk       = disp_qk;
               ent_d[free_idx].qj_valid = disp_qj_valid && !fj[32];
               ent_d[free_idx].qk_valid = disp_qk_valid && !fk[32];
               ent_d[free_idx].vj       = (disp_qj_valid && fj[32]) ? fj[31:0] : disp_vj;
               ent_d[free_idx].vk       = (disp_qk_valid && fk[32]) ? fk[31:0] : disp_vk;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         alu_valid_q <= 1'b0;
         alu_op_q    <= '0;
         alu_v1_q    <= '0;
         alu_v2_q    <= '0;
         alu_rob_q   <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
         alu_valid_q <= alu_valid_d;
         alu_op_q    <= alu_op_d;
         alu_v1_q    <= alu_v1_d;
         alu_v2_q    <= alu_v2_d;
         alu_rob_q   <= alu_rob_d;
      end
   end

   assign alu_valid  = alu_valid_q;
   assign alu_op     = alu_op_q;
   assign alu_v1     = alu_v1_q;
   assign alu_v2     = alu_v2_q;
   assign alu_rob_id = alu_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, corner sequences, randomized traffic vs a slot-array model.
module tb_alu_rs;

   logic        clk = 1'b0;
   logic        rst, rdy, clear, disp_valid;
   logic [4:0]  disp_op;
   logic [3:0]  disp_rob_id, disp_qj, disp_qk;
   logic [31:0] disp_vj, disp_vk;
   logic        disp_qj_valid, disp_qk_valid;
   logic        cdb_alu_valid, cdb_lsb_valid;
   logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
   logic [31:0] cdb_alu_value, cdb_lsb_value;
   logic        full, alu_valid;
   logic [4:0]  alu_op;
   logic [31:0] alu_v1, alu_v2;
   logic [3:0]  alu_rob_id;

   always #5 clk = ~clk;

   alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_rob_id(disp_rob_id),
      .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
      .disp_qj(disp_qj), .disp_qk(disp_qk),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
      .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
      .full(full), .alu_valid(alu_valid), .alu_op(alu_op),
      .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_rob_id(alu_rob_id)
   );

   typedef struct {
      bit rst, rdy, clear, dv;
      bit [4:0] op;
      bit [3:0] rob;
      bit [31:0] vj, vk;
      bit qjv; bit [3:0] qj;
      bit qkv; bit [3:0] qk;
      bit cav; bit [3:0] cat; bit [31:0] cad;
      bit clv; bit [3:0] clt; bit [31:0] cld;
   } drv_t;

   typedef struct {
      drv_t d;
      bit ev;
      bit [31:0] e1, e2;
      bit [3:0] erob;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: one record per slot plus the last issued payload.
   bit        m_busy[8];
   bit [4:0]  m_op[8];
   bit [31:0] m_vj[8], m_vk[8];
   bit        m_qjv[8], m_qkv[8];
   bit [3:0]  m_qj[8], m_qk[8], m_rob[8];
   bit        e_valid;
   bit [4:0]  e_op;
   bit [31:0] e_v1, e_v2;
   bit [3:0]  e_rob;

   function automatic drv_t idle();
      drv_t d;
      d = '{default: 0};
      d.rdy = 1'b1;
      return d;
   endfunction

   function automatic drv_t disp(bit [4:0] op, bit [3:0] rob, bit [31:0] vj, bit [31:0] vk,
                                 bit qjv, bit [3:0] qj, bit qkv, bit [3:0] qk);
      drv_t d;
      d = idle();
      d.dv = 1'b1; d.op = op; d.rob = rob; d.vj = vj; d.vk = vk;
      d.qjv = qjv; d.qj = qj; d.qkv = qkv; d.qk = qk;
      return d;
   endfunction

   function automatic drv_t with_ca(drv_t d, bit [3:0] t, bit [31:0] v);
      d.cav = 1'b1; d.cat = t; d.cad = v;
      return d;
   endfunction

   function automatic drv_t with_cl(drv_t d, bit [3:0] t, bit [31:0] v);
      d.clv = 1'b1; d.clt = t; d.cld = v;
      return d;
   endfunction

   function automatic vec_t mkv(drv_t d, bit ev, bit [31:0] e1, bit [31:0] e2, bit [3:0] er);
      vec_t v;
      v.d = d; v.ev = ev; v.e1 = e1; v.e2 = e2; v.erob = er;
      return v;
   endfunction

   task automatic lookup(input drv_t d, input bit [3:0] tag, output bit hit, output bit [31:0] val);
      hit = 1'b1;
      if (d.cav && d.cat == tag)      val = d.cad;
      else if (d.clv && d.clt == tag) val = d.cld;
      else begin hit = 1'b0; val = 32'd0; end
   endtask

   task automatic model(input drv_t d);
      int sel, fr;
      bit hit;
      bit [31:0] val;
      if (d.rst) begin
         for (int i = 0; i < 8; i++) begin
            m_busy[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_qjv[i] = 0;
            m_qkv[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_rob[i] = 0;
         end
         e_valid = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_rob = 0;
         return;
      end
      if (!d.rdy) return;
      if (d.clear) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 0;
         e_valid = 0;
         return;
      end
      sel = -1; fr = -1;
      for (int i = 0; i < 8; i++) begin
         if (sel < 0 && m_busy[i] && !m_qjv[i] && !m_qkv[i]) sel = i;
         if (fr < 0 && !m_busy[i]) fr = i;
      end
      for (int i = 0; i < 8; i++) begin
         if (!m_busy[i]) continue;
         lookup(d, m_qj[i], hit, val);
         if (m_qjv[i] && hit) begin m_vj[i] = val; m_qjv[i] = 0; end
         lookup(d, m_qk[i], hit, val);
         if (m_qkv[i] && hit) begin m_vk[i] = val; m_qkv[i] = 0; end
      end
      e_valid = (sel >= 0);
      if (sel >= 0) begin
         e_op = m_op[sel]; e_v1 = m_vj[sel]; e_v2 = m_vk[sel]; e_rob = m_rob[sel];
         m_busy[sel] = 0;
      end
      if (d.dv && fr >= 0) begin
         m_busy[fr] = 1; m_op[fr] = d.op; m_rob[fr] = d.rob; m_qj[fr] = d.qj; m_qk[fr] = d.qk;
         lookup(d, d.qj, hit, val);
         m_qjv[fr] = d.qjv && !hit;
         m_vj[fr]  = (d.qjv && hit) ? val : d.vj;
         lookup(d, d.qk, hit, val);
         m_qkv[fr] = d.qkv && !hit;
         m_vk[fr]  = (d.qkv && hit) ? val : d.vk;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input drv_t d);
      rst = d.rst; rdy = d.rdy; clear = d.clear; disp_valid = d.dv;
      disp_op = d.op; disp_rob_id = d.rob; disp_vj = d.vj; disp_vk = d.vk;
      disp_qj_valid = d.qjv; disp_qj = d.qj; disp_qk_valid = d.qkv; disp_qk = d.qk;
      cdb_alu_valid = d.cav; cdb_alu_rob_id = d.cat; cdb_alu_value = d.cad;
      cdb_lsb_valid = d.clv; cdb_lsb_rob_id = d.clt; cdb_lsb_value = d.cld;
   endtask

   task automatic step(input drv_t d);
      bit efull;
      apply(d);
      model(d);
      @(posedge clk);
      #1;
      efull = 1'b1;
      for (int i = 0; i < 8; i++) if (!m_busy[i]) efull = 1'b0;
      chk("mdl_valid", {31'd0, alu_valid}, {31'd0, e_valid});
      chk("mdl_op", {27'd0, alu_op}, {27'd0, e_op});
      chk("mdl_v1", alu_v1, e_v1);
      chk("mdl_v2", alu_v2, e_v2);
      chk("mdl_rob", {28'd0, alu_rob_id}, {28'd0, e_rob});
      chk("mdl_full", {31'd0, full}, {31'd0, efull});
   endtask

   vec_t vecs[13];
   drv_t d;

   initial begin
      vecs[0]  = mkv(disp(5'd0, 4'd2, 32'd3, 32'd4, 0, 0, 0, 0), 0, 32'd0, 32'd0, 4'd0);
      vecs[1]  = mkv(idle(), 1, 32'd3, 32'd4, 4'd2);
      vecs[2]  = mkv(idle(), 0, 32'd3, 32'd4, 4'd2);
      vecs[3]  = mkv(disp(5'd0, 4'd3, 32'd0, 32'd7, 1, 4'd5, 0, 0), 0, 32'd3, 32'd4, 4'd2);
      vecs[4]  = mkv(idle(), 0, 32'd3, 32'd4, 4'd2);
      vecs[5]  = mkv(with_cl(idle(), 4'd5, 32'h10), 0, 32'd3, 32'd4, 4'd2);
      vecs[6]  = mkv(idle(), 1, 32'h10, 32'd7, 4'd3);
      vecs[7]  = mkv(with_ca(disp(5'b01000, 4'd4, 32'd1, 32'd0, 0, 0, 1, 4'd6), 4'd6, 32'd9),
                     0, 32'h10, 32'd7, 4'd3);
      vecs[8]  = mkv(idle(), 1, 32'd1, 32'd9, 4'd4);
      vecs[9]  = mkv(disp(5'd1, 4'd5, 32'd0, 32'd2, 1, 4'd7, 0, 0), 0, 32'd1, 32'd9, 4'd4);
      vecs[10] = mkv(with_cl(with_ca(idle(), 4'd7, 32'hAA), 4'd7, 32'hBB), 0, 32'd1, 32'd9, 4'd4);
      vecs[11] = mkv(idle(), 1, 32'hAA, 32'd2, 4'd5);
      vecs[12] = mkv(idle(), 0, 32'hAA, 32'd2, 4'd5);

      d = idle(); d.rst = 1'b1;
      step(d);
      step(d);
      chk("rst_valid", {31'd0, alu_valid}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);

      for (int k = 0; k < 13; k++) begin
         step(vecs[k].d);
         chk($sformatf("tbl%0d_valid", k), {31'd0, alu_valid}, {31'd0, vecs[k].ev});
         chk($sformatf("tbl%0d_v1", k), alu_v1, vecs[k].e1);
         chk($sformatf("tbl%0d_v2", k), alu_v2, vecs[k].e2);
         chk($sformatf("tbl%0d_rob", k), {28'd0, alu_rob_id}, {28'd0, vecs[k].erob});
         chk($sformatf("tbl%0d_full", k), {31'd0, full}, 32'd0);
      end

      // Fill all slots waiting on tag 1, overflow, then release in index order.
      for (int i = 0; i < 8; i++) step(disp(5'd2, 4'(i), 32'd0, 32'(i + 100), 1, 4'd1, 0, 0));
      chk("fill_full", {31'd0, full}, 32'd1);
      step(disp(5'd0, 4'd15, 32'd1, 32'd1, 0, 0, 0, 0));
      chk("ovf_full", {31'd0, full}, 32'd1);
      chk("ovf_noissue", {31'd0, alu_valid}, 32'd0);
      step(with_ca(idle(), 4'd1, 32'h100));
      for (int i = 0; i < 8; i++) begin
         step(idle());
         chk("order_valid", {31'd0, alu_valid}, 32'd1);
         chk("order_rob", {28'd0, alu_rob_id}, 32'(i));
         chk("order_v2", alu_v2, 32'(i + 100));
         if (i == 0) chk("full_drop", {31'd0, full}, 32'd0);
      end
      step(idle());
      chk("drain_valid", {31'd0, alu_valid}, 32'd0);

      // Flush with concurrent dispatch and wakeup: nothing survives.
      for (int i = 1; i <= 3; i++) step(disp(5'd3, 4'(i), 32'd0, 32'd0, 1, 4'd2, 0, 0));
      d = with_ca(disp(5'd4, 4'd9, 32'd5, 32'd6, 0, 0, 0, 0), 4'd2, 32'h22);
      d.clear = 1'b1;
      step(d);
      chk("clr_valid", {31'd0, alu_valid}, 32'd0);
      chk("clr_full", {31'd0, full}, 32'd0);
      step(with_ca(idle(), 4'd2, 32'h22));
      for (int i = 0; i < 3; i++) begin
         step(idle());
         chk("clr_noissue", {31'd0, alu_valid}, 32'd0);
      end

      // Freeze mid-stream: outputs hold while junk traffic and clear are presented.
      step(disp(5'd5, 4'd6, 32'h61, 32'h62, 0, 0, 0, 0));
      step(disp(5'd6, 4'd7, 32'h71, 32'h72, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         d = with_ca(disp(5'd7, 4'd8, 32'h81, 32'h82, 0, 0, 0, 0), 4'd0, 32'h0);
         d.rdy = 1'b0; d.clear = 1'b1;
         step(d);
         chk("frz_valid", {31'd0, alu_valid}, 32'd1);
         chk("frz_rob", {28'd0, alu_rob_id}, 32'd6);
      end
      step(idle());
      chk("resume_rob", {28'd0, alu_rob_id}, 32'd7);
      chk("resume_valid", {31'd0, alu_valid}, 32'd1);
      step(idle());

      // Reset with busy slots, regardless of rdy; next dispatch is the only survivor.
      for (int i = 0; i < 4; i++) step(disp(5'd8, 4'(i + 10), 32'd1, 32'd2, 1, 4'd3, 0, 0));
      d = idle(); d.rst = 1'b1; d.rdy = 1'b0;
      step(d);
      chk("rst2_valid", {31'd0, alu_valid}, 32'd0);
      chk("rst2_v1", alu_v1, 32'd0);
      chk("rst2_v2", alu_v2, 32'd0);
      chk("rst2_rob", {28'd0, alu_rob_id}, 32'd0);
      chk("rst2_op", {27'd0, alu_op}, 32'd0);
      step(disp(5'd9, 4'd9, 32'h55, 32'h66, 0, 0, 0, 0));
      step(idle());
      chk("rst2_first_rob", {28'd0, alu_rob_id}, 32'd9);
      chk("rst2_first_v1", alu_v1, 32'h55);
      step(with_ca(idle(), 4'd3, 32'h33));
      step(idle());
      chk("rst2_gone", {31'd0, alu_valid}, 32'd0);

      for (int n = 0; n < 600; n++) begin
         d = idle();
         d.rst   = ($urandom_range(0, 99) == 0);
         d.rdy   = ($urandom_range(0, 9) != 0);
         d.clear = ($urandom_range(0, 39) == 0);
         d.dv    = $urandom_range(0, 1);
         d.op    = 5'($urandom);
         d.rob   = 4'($urandom);
         d.vj    = $urandom;
         d.vk    = $urandom;
         d.qjv   = ($urandom_range(0, 2) == 0);
         d.qj    = 4'($urandom_range(0, 3));
         d.qkv   = ($urandom_range(0, 2) == 0);
         d.qk    = 4'($urandom_range(0, 3));
         d.cav   = $urandom_range(0, 1);
         d.cat   = 4'($urandom_range(0, 3));
         d.cad   = $urandom;
         d.clv   = $urandom_range(0, 1);
         d.clt   = 4'($urandom_range(0, 3));
         d.cld   = $urandom;
         step(d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
